// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bus: the instruction descriptor in, the stall decision and scoreboard status out.
// The master drives the instruction; the scoreboard is the slave.
interface hazard_scoreboard_unit_if #(
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_W-1:0]  src_addr;
  logic [NUM_SRC-1:0]        src_valid;
  logic [REG_W-1:0]          dest_addr;
  logic                      wb_en;
  logic                      is_load;
  logic                      forward_en;
  logic                      flush;
  logic                      stall;
  logic [(2**REG_W)-1:0]     busy_mask;
  logic [CNT_W-1:0]          hazard_cnt;

  modport master (
    output id_valid, src_addr, src_valid, dest_addr, wb_en, is_load, forward_en, flush,
    input  stall, busy_mask, hazard_cnt
  );

  modport slave (
    input  id_valid, src_addr, src_valid, dest_addr, wb_en, is_load, forward_en, flush,
    output stall, busy_mask, hazard_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Register scoreboard: each register has a pending-latency down-counter.
// An ID instruction stalls while any source it reads has a nonzero count.
module hazard_scoreboard_unit #(
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_LAT = 1,
  parameter int WB_LAT   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_scoreboard_unit_if.slave   bus
);
  localparam int NUM_REG = 2**REG_W;
  localparam int MAX_LAT = (LOAD_LAT > WB_LAT) ? LOAD_LAT : WB_LAT;
  localparam int PEND_W  = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [PEND_W-1:0]  pend_q [NUM_REG];
  logic [PEND_W-1:0]  pend_d [NUM_REG];
  logic [NUM_REG-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   hazard_cnt_q, hazard_cnt_d;
  logic               src_hit;
  logic               stall_c;
  logic               issue;
  logic [PEND_W-1:0]  issue_lat;

  // Sources look at pre-edge counts, so an instruction never sees its own write.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_valid[i] && (pend_q[bus.src_addr[i*REG_W +: REG_W]] != '0)) begin
        src_hit = 1'b1;
      end
    end
    stall_c = bus.id_valid && !bus.flush && src_hit;
    issue   = bus.id_valid && bus.wb_en && !stall_c && !bus.flush;
  end

  always_comb begin
    issue_lat = '0;
    if (!bus.forward_en) begin
      issue_lat = PEND_W'(WB_LAT);
    end else if (bus.is_load) begin
      issue_lat = PEND_W'(LOAD_LAT);
    end
  end

  // Newest writer overwrites the count outright, even with zero.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      pend_d[r] = '0;
      if (issue && (bus.dest_addr == REG_W'(r))) begin
        pend_d[r] = issue_lat;
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end
      busy_d[r] = (pend_d[r] != '0);
    end
  end

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (stall_c && (hazard_cnt_q != {CNT_W{1'b1}})) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REG; r++) begin
        pend_q[r] <= '0;
      end
      busy_q       <= '0;
      hazard_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      busy_q       <= busy_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.busy_mask  = busy_q;
  assign bus.hazard_cnt = hazard_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for the hazard scoreboard; a second instance with a 2-bit counter
// sees the same stimulus to exercise statistics saturation.
module tb_hazard_scoreboard_unit;
  logic clk;
  logic rst_n;
  logic        id_valid;
  logic [11:0] src_addr;
  logic [2:0]  src_valid;
  logic [3:0]  dest_addr;
  logic        wb_en;
  logic        is_load;
  logic        forward_en;
  logic        flush;

  int n_checks;
  int n_fail;

  hazard_scoreboard_unit_if #(.REG_W(4), .NUM_SRC(3), .CNT_W(16)) bus ();
  hazard_scoreboard_unit_if #(.REG_W(4), .NUM_SRC(3), .CNT_W(2))  bus_sat ();

  assign bus.id_valid       = id_valid;
  assign bus.src_addr       = src_addr;
  assign bus.src_valid      = src_valid;
  assign bus.dest_addr      = dest_addr;
  assign bus.wb_en          = wb_en;
  assign bus.is_load        = is_load;
  assign bus.forward_en     = forward_en;
  assign bus.flush          = flush;
  assign bus_sat.id_valid   = id_valid;
  assign bus_sat.src_addr   = src_addr;
  assign bus_sat.src_valid  = src_valid;
  assign bus_sat.dest_addr  = dest_addr;
  assign bus_sat.wb_en      = wb_en;
  assign bus_sat.is_load    = is_load;
  assign bus_sat.forward_en = forward_en;
  assign bus_sat.flush      = flush;

  hazard_scoreboard_unit #(
    .REG_W(4), .NUM_SRC(3), .LOAD_LAT(1), .WB_LAT(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  hazard_scoreboard_unit #(
    .REG_W(4), .NUM_SRC(3), .LOAD_LAT(1), .WB_LAT(2), .CNT_W(2)
  ) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [3:0] s2, input logic [3:0] s1,
                       input logic [3:0] s0, input logic [2:0] sv, input logic [3:0] d,
                       input logic we, input logic ld, input logic fe, input logic fl);
    id_valid   = v;
    src_addr   = {s2, s1, s0};
    src_valid  = sv;
    dest_addr  = d;
    wb_en      = we;
    is_load    = ld;
    forward_en = fe;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'd3, 4'd2, 4'd1, 3'b111, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    apply_reset();
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
    n_checks++;
    if (bus.busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL reset_busy: got %h expected 0000", bus.busy_mask);
    end
    n_checks++;
    if (bus.hazard_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.hazard_cnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_issue_stall: got %b expected 0", bus.stall);
    end
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd3, 3'b001, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall_c1: got %b expected 1", bus.stall);
    end
    n_checks++;
    if (bus.busy_mask !== 16'h0008) begin
      n_fail++; $display("FAIL lu_busy_c1: got %h expected 0008", bus.busy_mask);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall_c2: got %b expected 0", bus.stall);
    end
    n_checks++;
    if (bus.hazard_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_cnt: got %0d expected 1", bus.hazard_cnt);
    end
    n_checks++;
    if (bus.busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL lu_busy_c2: got %h expected 0000", bus.busy_mask);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_no_forward();
    logic [2:0] exp_stall;
    logic [2:0] exp_busy;
    exp_stall = 3'b011;
    exp_busy  = 3'b011;
    apply_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd5, 4'd0, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.stall !== exp_stall[c]) begin
        n_fail++; $display("FAIL nf_stall_c%0d: got %b expected %b", c, bus.stall, exp_stall[c]);
      end
      n_checks++;
      if (bus.busy_mask[5] !== exp_busy[c]) begin
        n_fail++; $display("FAIL nf_busy5_c%0d: got %b expected %b", c, bus.busy_mask[5], exp_busy[c]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.hazard_cnt !== 16'd2) begin
      n_fail++; $display("FAIL nf_cnt: got %0d expected 2", bus.hazard_cnt);
    end
    idle();
  endtask

  task automatic test_src_gating();
    apply_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd5, 4'd2, 4'd1, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL gate_masked: got %b expected 0", bus.stall);
    end
    src_valid = 3'b100;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL gate_src2_valid: got %b expected 1", bus.stall);
    end
    id_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL gate_no_valid: got %b expected 0", bus.stall);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_waw();
    apply_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.busy_mask[7] !== 1'b1) begin
      n_fail++; $display("FAIL waw_busy_first: got %b expected 1", bus.busy_mask[7]);
    end
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd7, 3'b001, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.busy_mask[7] !== 1'b0) begin
      n_fail++; $display("FAIL waw_busy_after: got %b expected 0", bus.busy_mask[7]);
    end
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_stall: got %b expected 0", bus.stall);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_flush_reset();
    apply_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd3, 3'b001, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.stall);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (bus.busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL flush_busy: got %h expected 0000", bus.busy_mask);
    end
    n_checks++;
    if (bus.hazard_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_cnt: got %0d expected 0", bus.hazard_cnt);
    end
    drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd3, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_stall: got %b expected 1", bus.stall);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_busy: got %h expected 0000", bus.busy_mask);
    end
    n_checks++;
    if (bus.hazard_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt: got %0d expected 0", bus.hazard_cnt);
    end
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", bus.stall);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'd0, 4'd0, 4'd3, 3'b001, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      n_checks++;
      if (bus_sat.hazard_cnt !== exp_sat[k]) begin
        n_fail++; $display("FAIL sat_cnt_pair%0d: got %0d expected %0d", k, bus_sat.hazard_cnt, exp_sat[k]);
      end
      n_checks++;
      if (bus.hazard_cnt !== 16'(k + 1)) begin
        n_fail++; $display("FAIL wide_cnt_pair%0d: got %0d expected %0d", k, bus.hazard_cnt, k + 1);
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_forward();
    test_src_gating();
    test_waw();
    test_flush_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter REG_W, default 4: register address width; scoreboard holds 2**REG_W entries.
REQ-002 Parameter NUM_SRC, default 3: number of source operands checked per instruction.
REQ-003 Parameter LOAD_LAT, default 1: stall cycles for a load result with forwarding on.
REQ-004 Parameter WB_LAT, default 2: stall cycles for any result with forwarding off.
REQ-005 Parameter CNT_W, default 16: width of the hazard statistics counter.
REQ-006 Port clk, input, 1: single clock; every state element updates on the rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port id_valid, input, 1: valid instruction present in ID.
REQ-009 Port src_addr, input, NUM_SRC*REG_W: packed sources; source i occupies [i*REG_W +: REG_W].
REQ-010 Port src_valid, input, NUM_SRC: bit i set means source i is actually read.
REQ-011 Port dest_addr, input, REG_W: destination register of the ID instruction.
REQ-012 Port wb_en, input, 1: ID instruction writes dest_addr.
REQ-013 Port is_load, input, 1: ID instruction is a memory load.
REQ-014 Port forward_en, input, 1: runtime forwarding mode, 1 = forwarding path active.
REQ-015 Port flush, input, 1: ID instruction is being squashed this cycle.
REQ-016 Port stall, output, 1: freeze IF/ID and insert a bubble into EXE.
REQ-017 Port busy_mask, output, 2**REG_W: bit r set while register r has a nonzero pending count.
REQ-018 Port hazard_cnt, output, CNT_W: count of stall cycles since reset.

Function
REQ-019 The block SHALL keep one pending counter per register, of width clog2(max(LOAD_LAT,WB_LAT)+1) bits.
REQ-020 stall SHALL be combinational: id_valid && !flush && (for some i: src_valid[i] && pend[src_addr[i]] != 0).
REQ-021 Sources SHALL be compared against the pre-edge counter values; the instruction's own dest_addr SHALL never hazard against itself.
REQ-022 Issue SHALL occur on a cycle where id_valid && wb_en && !stall && !flush.
REQ-023 On issue, the latency SHALL be LOAD_LAT if forward_en && is_load; 0 if forward_en && !is_load; WB_LAT if !forward_en.
REQ-024 On issue, pend[dest_addr] SHALL be written with that latency, overwriting any older value (WAW: the newest writer wins, including 0).
REQ-025 Each cycle, every nonzero counter not written by an issue SHALL decrement by 1; a zero counter SHALL remain 0.
REQ-026 Counters SHALL keep decrementing while stall is asserted; a stalled or flushed instruction SHALL record nothing.
REQ-027 Changing forward_en SHALL NOT alter existing counters; only later issues use the new mode.
REQ-028 busy_mask[r] SHALL equal (pend[r] != 0), driven from registers with no combinational input path.
REQ-029 hazard_cnt SHALL increment on each clock edge where stall=1, and SHALL saturate at all-ones.
REQ-030 For flush=1 with id_valid=1, stall SHALL be 0 and no issue SHALL be recorded; decrement SHALL continue.

Reset
REQ-031 On a clk edge with rst_n=0, all pend counters and hazard_cnt SHALL become 0, so busy_mask=0 and stall=0 until a new issue occurs.
REQ-032 Reset SHALL take priority over issue and decrement, including in the middle of a stall sequence.

Verification
REQ-033 Load-use with forward_en=1: issue a load to r3, then next cycle src0=r3 valid -> stall=1 for exactly 1 cycle, then 0, and hazard_cnt=1.
REQ-034 No forwarding with forward_en=0: issue an ALU op to r5, then next instruction src1=r5 -> stall=1 for 2 cycles, and busy_mask[5] goes 1,1,0.
REQ-035 Source gating: pending r5 with src2=r5 and src_valid=3'b011 -> stall=0.
REQ-036 WAW overwrite: issue r7 with forward_en=0 (pend=2), then issue r7 with forward_en=1 and an ALU op -> busy_mask[7]=0 on the next cycle and no stall for a consumer of r7.
REQ-037 Flush and reset: load to r3, then consumer of r3 with flush=1 -> stall=0; load to r3, then rst_n=0 for one edge -> busy_mask=0 and hazard_cnt=0.
REQ-038 Saturation with CNT_W=2: five back-to-back load-use pairs -> hazard_cnt reads 1,2,3,3,3.
